alu_issue_unit: RTL and testbench

Sequential front end that issues operations to a combinational ALU instance and returns its results over a valid/ready handshake. It registers each accepted request, drives the ALU operand and function ports for one cycle, captures the result and overflow flag, and buffers up to two responses in order. A saturating counter tracks overflowing results delivered downstream. The block sits between an instruction or test sequencer and the ALU.

---
 rtl/alu_issue_unit_if.sv | 50 +++++
 rtl/alu_issue_unit.sv | 105 ++++++++++
 tb/tb_alu_issue_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_if.sv
// Bundle of request, ALU-drive, response and counter signals between a
// sequencer (master) and the ALU issue unit (slave).
interface alu_issue_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [3:0]            req_func;
  logic [TAG_WIDTH-1:0]  req_tag;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_func;
  logic [DATA_WIDTH-1:0] alu_c;
  logic                  alu_ovf;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_c;
  logic                  rsp_ovf;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  logic [7:0]            ovf_count;
  logic                  clear_count;

  modport slave (
    input  req_valid, req_a, req_b, req_func, req_tag,
    output req_ready,
    output alu_a, alu_b, alu_func,
    input  alu_c, alu_ovf,
    output rsp_valid, rsp_c, rsp_ovf, rsp_tag,
    input  rsp_ready,
    output ovf_count,
    input  clear_count
  );

  modport master (
    output req_valid, req_a, req_b, req_func, req_tag,
    input  req_ready,
    input  alu_a, alu_b, alu_func,
    output alu_c, alu_ovf,
    input  rsp_valid, rsp_c, rsp_ovf, rsp_tag,
    output rsp_ready,
    input  ovf_count,
    output clear_count
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue front end for a combinational ALU: one execute register stage,
// a 2-entry first-word-fall-through response buffer and a saturating overflow counter.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
) (
  input logic              clk,
  input logic              reset_n,
  alu_issue_unit_if.slave  bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] c;
    logic                  ovf;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  localparam logic [3:0] FUNC_ZERO = 4'b1111;

  logic                  e_valid_q;
  logic [DATA_WIDTH-1:0] e_a_q;
  logic [DATA_WIDTH-1:0] e_b_q;
  logic [3:0]            e_func_q;
  logic [TAG_WIDTH-1:0]  e_tag_q;

  rsp_t [1:0]            fifo_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [7:0]            ovf_count_q;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;
  rsp_t                  head;

  assign push      = e_valid_q;
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = bus.rsp_valid && bus.rsp_ready;

  // Results still owed downstream after this edge; an accepted request must
  // always find a free FIFO slot by the time it is captured.
  assign occupancy     = {1'b0, count_q} + {2'b00, e_valid_q} - {2'b00, pop};
  assign bus.req_ready = (occupancy < 3'd2);
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.alu_a    = e_a_q;
  assign bus.alu_b    = e_b_q;
  assign bus.alu_func = e_valid_q ? e_func_q : FUNC_ZERO;

  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_c     = head.c;
  assign bus.rsp_ovf   = head.ovf;
  assign bus.rsp_tag   = head.tag;
  assign bus.ovf_count = ovf_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid_q <= 1'b0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_func_q  <= '0;
      e_tag_q   <= '0;
    end else if (accept) begin
      e_valid_q <= 1'b1;
      e_a_q     <= bus.req_a;
      e_b_q     <= bus.req_b;
      e_func_q  <= bus.req_func;
      e_tag_q   <= bus.req_tag;
    end else begin
      e_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.alu_c, bus.alu_ovf, e_tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Clear wins over a same-edge overflowing pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count_q <= 8'd0;
    end else if (bus.clear_count) begin
      ovf_count_q <= 8'd0;
    end else if (pop && head.ovf && (ovf_count_q != 8'hFF)) begin
      ovf_count_q <= ovf_count_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, queue-based response model,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_alu_issue_unit;
  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_issue_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  alu_issue_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Attached ALU: 0 add, 1 sub (signed overflow), 2 and, 3 or, 4 xor, 5 shl, others zero.
  function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [3:0] f);
    logic [DW-1:0] c;
    logic o;
    c = '0;
    o = 1'b0;
    case (f)
      4'd0: begin c = a + b; o = (a[DW-1] == b[DW-1]) && (c[DW-1] != a[DW-1]); end
      4'd1: begin c = a - b; o = (a[DW-1] != b[DW-1]) && (c[DW-1] != a[DW-1]); end
      4'd2: c = a & b;
      4'd3: c = a | b;
      4'd4: c = a ^ b;
      4'd5: c = a << b[3:0];
      default: begin c = '0; o = 1'b0; end
    endcase
    return {o, c};
  endfunction

  assign {bus.alu_ovf, bus.alu_c} = alu_f(bus.alu_a, bus.alu_b, bus.alu_func);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] c;
    logic          ovf;
    logic [TW-1:0] tag;
    logic [3:0]    func;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] c;
    logic          ovf;
    logic [TW-1:0] tag;
  } log_t;

  // Model: every accepted, not yet delivered request in order; the newest one
  // is still in the ALU stage if it was accepted on the last edge.
  exp_t mq[$];
  bit   last_acc = 1'b0;
  int   m_cnt = 0;
  int   cyc_n = 0;
  bit   will_acc = 1'b0, will_pop = 1'b0, will_clr = 1'b0;
  exp_t will_item;
  log_t plog[$];

  always @(negedge clk) begin
    if (reset_n) begin
      int   buffered;
      bit   ev, pn, er;
      logic [3:0] ef;
      logic [DW:0] r;
      buffered = mq.size() - (last_acc ? 1 : 0);
      ev = (buffered > 0);
      ef = last_acc ? mq[mq.size()-1].func : 4'hF;
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
      chk("alu_func", {28'd0, bus.alu_func}, {28'd0, ef});
      if (ev) begin
        chk("rsp_c", {16'd0, bus.rsp_c}, {16'd0, mq[0].c});
        chk("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, mq[0].ovf});
        chk("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, mq[0].tag});
      end
      pn = ev && bus.rsp_ready;
      er = ((mq.size() - (pn ? 1 : 0)) < 2);
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, er});
      chk("ovf_count", {24'd0, bus.ovf_count}, m_cnt);
      if (pn) plog.push_back('{cyc_n, bus.rsp_c, bus.rsp_ovf, bus.rsp_tag});
      r = alu_f(bus.req_a, bus.req_b, bus.req_func);
      will_item = '{r[DW-1:0], r[DW], bus.req_tag, bus.req_func};
      will_acc  = bus.req_valid && er;
      will_pop  = pn;
      will_clr  = bus.clear_count;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      bit pop_ovf;
      pop_ovf = 1'b0;
      cyc_n++;
      if (will_pop) begin
        pop_ovf = mq[0].ovf;
        void'(mq.pop_front());
      end
      if (will_clr) m_cnt = 0;
      else if (pop_ovf && m_cnt < 255) m_cnt++;
      if (will_acc) mq.push_back(will_item);
      last_acc = will_acc;
      will_acc = 1'b0;
      will_pop = 1'b0;
      will_clr = 1'b0;
    end
  end

  always @(negedge reset_n) begin
    mq.delete();
    last_acc = 1'b0;
    m_cnt    = 0;
    will_acc = 1'b0;
    will_pop = 1'b0;
    will_clr = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] f, input logic [TW-1:0] t);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_func  = f;
    bus.req_tag   = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] funcs [8];
    funcs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'hF};
    bus.req_valid   = 1'b0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_func    = '0;
    bus.req_tag     = '0;
    bus.rsp_ready   = 1'b0;
    bus.clear_count = 1'b0;

    // Reset values while reset is held
    #3;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_rsp_c", {16'd0, bus.rsp_c}, 0);
    chk("rst_rsp_ovf", {31'd0, bus.rsp_ovf}, 0);
    chk("rst_rsp_tag", {28'd0, bus.rsp_tag}, 0);
    chk("rst_alu_func", {28'd0, bus.alu_func}, 32'hF);
    chk("rst_alu_a", {16'd0, bus.alu_a}, 0);
    chk("rst_ovf_count", {24'd0, bus.ovf_count}, 0);
    #9 reset_n = 1'b1;
    #1 chk("rst_req_ready", {31'd0, bus.req_ready}, 1);

    // Idle drive
    step(); step();
    chk("idle_alu_func", {28'd0, bus.alu_func}, 32'hF);
    chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 0);

    // Overflow add
    offer(16'h7FFF, 16'h0001, 4'd0, 4'd3);
    chk("ovf_req_ready", {31'd0, bus.req_ready}, 1);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("ovf_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    chk("ovf_rsp_c", {16'd0, bus.rsp_c}, 32'h8000);
    chk("ovf_rsp_ovf", {31'd0, bus.rsp_ovf}, 1);
    chk("ovf_rsp_tag", {28'd0, bus.rsp_tag}, 3);
    bus.rsp_ready = 1'b1;
    step();
    chk("ovf_count_after_pop", {24'd0, bus.ovf_count}, 1);
    chk("ovf_fifo_empty", {31'd0, bus.rsp_valid}, 0);

    // Streaming subtracts
    plog.delete();
    for (int i = 0; i < 4; i++) begin
      offer(16'h0005, 16'h0003, 4'd1, i[TW-1:0]);
      chk("stream_req_ready", {31'd0, bus.req_ready}, 1);
      step();
    end
    bus.req_valid = 1'b0;
    step(); step(); step();
    chk("stream_count", plog.size(), 4);
    if (plog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("stream_tag", {28'd0, plog[i].tag}, i);
        chk("stream_c", {16'd0, plog[i].c}, 32'h0002);
        chk("stream_consecutive", plog[i].cyc - plog[0].cyc, i);
      end
    end

    // Backpressure
    bus.rsp_ready = 1'b0;
    plog.delete();
    offer(16'h00F0, 16'h0F0F, 4'd2, 4'd10);
    chk("bp_ready0", {31'd0, bus.req_ready}, 1);
    step();
    offer(16'h1234, 16'h4321, 4'd3, 4'd11);
    chk("bp_ready1", {31'd0, bus.req_ready}, 1);
    step();
    offer(16'hAAAA, 16'h5555, 4'd4, 4'd12);
    chk("bp_ready2_blocked", {31'd0, bus.req_ready}, 0);
    step();
    chk("bp_ready3_blocked", {31'd0, bus.req_ready}, 0);
    step();
    chk("bp_head_tag", {28'd0, bus.rsp_tag}, 10);
    chk("bp_head_c", {16'd0, bus.rsp_c}, 32'h0000);
    bus.rsp_ready = 1'b1;
    #1 chk("bp_ready_on_pop", {31'd0, bus.req_ready}, 1);
    step();
    bus.req_valid = 1'b0;
    step(); step(); step(); step();
    chk("bp_count", plog.size(), 3);
    if (plog.size() == 3) begin
      chk("bp_tag0", {28'd0, plog[0].tag}, 10);
      chk("bp_tag1", {28'd0, plog[1].tag}, 11);
      chk("bp_tag2", {28'd0, plog[2].tag}, 12);
      chk("bp_c1", {16'd0, plog[1].c}, 32'h5335);
      chk("bp_c2", {16'd0, plog[2].c}, 32'hFFFF);
    end

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.req_valid   = ($urandom_range(0, 3) != 0);
      bus.req_a       = ($urandom_range(0, 3) == 0) ? 16'h7FF0 + 16'($urandom_range(0, 31)) : 16'($urandom);
      bus.req_b       = 16'($urandom);
      bus.req_func    = funcs[$urandom_range(0, 7)];
      bus.req_tag     = 4'($urandom);
      bus.rsp_ready   = ($urandom_range(0, 9) < 7);
      bus.clear_count = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.req_valid   = 1'b0;
    bus.rsp_ready   = 1'b1;
    bus.clear_count = 1'b0;
    step(); step(); step(); step();

    // Saturation after 300 overflowing pops
    bus.clear_count = 1'b1;
    step();
    bus.clear_count = 1'b0;
    for (int i = 0; i < 300; i++) begin
      offer(16'h7FFF, 16'h0001, 4'd0, i[TW-1:0]);
      step();
    end
    bus.req_valid = 1'b0;
    step(); step(); step();
    chk("sat_ovf_count", {24'd0, bus.ovf_count}, 255);

    // Clear on the same edge as an overflowing pop
    bus.rsp_ready = 1'b0;
    offer(16'h8000, 16'h0001, 4'd1, 4'd5);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("clr_rsp_ovf", {31'd0, bus.rsp_ovf}, 1);
    bus.rsp_ready   = 1'b1;
    bus.clear_count = 1'b1;
    step();
    bus.clear_count = 1'b0;
    chk("clr_ovf_count", {24'd0, bus.ovf_count}, 0);

    // Reset with results in flight
    offer(16'h7FFF, 16'h7FFF, 4'd0, 4'd1);
    step();
    bus.req_valid = 1'b0;
    step(); step();
    chk("mid_ovf_count_pre", {24'd0, bus.ovf_count}, 1);
    bus.rsp_ready = 1'b0;
    offer(16'h0001, 16'h0002, 4'd0, 4'd6);
    step();
    offer(16'h0003, 16'h0004, 4'd0, 4'd7);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("mid_ovf_count", {24'd0, bus.ovf_count}, 0);
    chk("mid_alu_func", {28'd0, bus.alu_func}, 32'hF);
    plog.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk("mid_req_ready", {31'd0, bus.req_ready}, 1);
    step(); step(); step(); step();
    chk("mid_no_stale", plog.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
